// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cmp_arbiter
// Brief   : Round-robin sharing of one branch comparator among NREQ issue
//           ports, with a one-entry valid/ready response slot.
// Revision: 1.0
// ============================================================================
module cmp_arbiter #(
    parameter  int NREQ = 2,
    parameter  int XLEN = 32,
    parameter  int TAGW = 4,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*XLEN-1:0] i_req_a,
    input  logic [NREQ*XLEN-1:0] i_req_b,
    input  logic [NREQ*3-1:0]    i_req_cmpop,
    input  logic [NREQ*TAGW-1:0] i_req_tag,
    output logic [XLEN-1:0]      o_cmp_a,
    output logic [XLEN-1:0]      o_cmp_b,
    output logic [2:0]           o_cmp_cmpop,
    input  logic                 i_cmp_taken,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_taken,
    output logic                 o_rsp_illegal,
    output logic [IDXW-1:0]      o_rsp_idx,
    output logic [TAGW-1:0]      o_rsp_tag
);

    localparam logic [IDXW:0]   c_nreq     = (IDXW+1)'(NREQ);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NREQ - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    logic [XLEN-1:0] w_a     [NREQ];
    logic [XLEN-1:0] w_b     [NREQ];
    logic [2:0]      w_cmpop [NREQ];
    logic [TAGW-1:0] w_tag   [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign w_a[k]     = i_req_a[k*XLEN +: XLEN];
        assign w_b[k]     = i_req_b[k*XLEN +: XLEN];
        assign w_cmpop[k] = i_req_cmpop[k*3 +: 3];
        assign w_tag[k]   = i_req_tag[k*TAGW +: TAGW];
    end

    slot_state_e     state_q;
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic            w_can_accept;
    logic [NREQ-1:0] w_rot;
    logic            w_gnt_any;
    logic [IDXW-1:0] w_gnt_idx;
    logic [IDXW:0]   w_sum;
    logic            w_illegal;

    // Reset gates the grant so no handshake is offered while flops are held.
    assign w_can_accept = i_rst_n & ~i_flush & ((state_q == EMPTY) | i_rsp_ready);

    // Bit 0 of the rotated vector is the requester at the pointer.
    assign w_rot = NREQ'({i_req_valid, i_req_valid} >> ptr_q);

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = ptr_q;
        w_sum     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_any && w_can_accept && w_rot[i]) begin
                w_gnt_any = 1'b1;
                w_sum     = (IDXW+1)'(ptr_q) + (IDXW+1)'(i);
                if (w_sum >= c_nreq) begin
                    w_sum = w_sum - c_nreq;
                end
                w_gnt_idx = w_sum[IDXW-1:0];
            end
        end
    end

    assign ptr_d = (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        o_req_ready = '0;
        if (w_gnt_any) begin
            o_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Without a grant the pointer's operands are shown, keeping the comparator inputs defined.
    assign o_cmp_a     = w_a[w_gnt_idx];
    assign o_cmp_b     = w_b[w_gnt_idx];
    assign o_cmp_cmpop = w_cmpop[w_gnt_idx];

    // Legal encodings are 000/001/100/101/110/111; 010 and 011 are unused.
    assign w_illegal = (o_cmp_cmpop[2:1] == 2'b01);

    assign o_rsp_valid = (state_q == FULL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= EMPTY;
            ptr_q         <= '0;
            o_rsp_taken   <= 1'b0;
            o_rsp_illegal <= 1'b0;
            o_rsp_idx     <= '0;
            o_rsp_tag     <= '0;
        end else if (i_flush) begin
            state_q <= EMPTY;
        end else if (w_gnt_any) begin
            state_q       <= FULL;
            ptr_q         <= ptr_d;
            o_rsp_taken   <= ~w_illegal & i_cmp_taken;
            o_rsp_illegal <= w_illegal;
            o_rsp_idx     <= w_gnt_idx;
            o_rsp_tag     <= w_tag[w_gnt_idx];
        end else if (i_rsp_ready) begin
            state_q <= EMPTY;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmp_arbiter
// Brief   : Directed self-checking bench for cmp_arbiter with a per-cycle
//           reference model and hand-computed literal expectations.
// Revision: 1.0
// ============================================================================
module tb_cmp_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int TAGW = 4;
    localparam int IDXW = 1;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;
    localparam logic [2:0] BBAD = 3'b010;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [NREQ*3-1:0]    req_op;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [XLEN-1:0]      cmp_a;
    logic [XLEN-1:0]      cmp_b;
    logic [2:0]           cmp_op;
    logic                 cmp_taken;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_taken;
    logic                 rsp_illegal;
    logic [IDXW-1:0]      rsp_idx;
    logic [TAGW-1:0]      rsp_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011);
    endfunction

    function automatic logic cmp_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                    input logic [2:0] op);
        case (op)
            BEQ:     return a == b;
            BNE:     return a != b;
            BLT:     return $signed(a) <  $signed(b);
            BGE:     return $signed(a) >= $signed(b);
            BLTU:    return a <  b;
            BGEU:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // The shared comparator the arbiter fronts.
    assign cmp_taken = cmp_fn(cmp_a, cmp_b, cmp_op);

    cmp_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .TAGW(TAGW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_cmpop  (req_op),
        .i_req_tag    (req_tag),
        .o_cmp_a      (cmp_a),
        .o_cmp_b      (cmp_b),
        .o_cmp_cmpop  (cmp_op),
        .i_cmp_taken  (cmp_taken),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_taken  (rsp_taken),
        .o_rsp_illegal(rsp_illegal),
        .o_rsp_idx    (rsp_idx),
        .o_rsp_tag    (rsp_tag)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   m_ptr, n_ptr;
    bit   m_valid, n_valid, m_taken, n_taken, m_illegal, n_illegal;
    int   m_idx, n_idx;
    int   m_tag, n_tag;
    bit   n_live = 1'b0;

    always @(negedge clk) begin
        int g;
        int s;
        int k;
        bit can;
        logic [NREQ-1:0] exp_ready;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_taken = 0; m_illegal = 0; m_idx = 0; m_tag = 0;
            n_live = 0;
            chk("m_rst_valid", 64'(rsp_valid), 64'(0));
            chk("m_rst_ready", 64'(req_ready), 64'(0));
        end else begin
            chk("m_valid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("m_taken",   64'(rsp_taken),   64'(m_taken));
                chk("m_illegal", 64'(rsp_illegal), 64'(m_illegal));
                chk("m_idx",     64'(rsp_idx),     64'(m_idx));
                chk("m_tag",     64'(rsp_tag),     64'(m_tag));
            end
            can = !flush && (!m_valid || rsp_ready);
            g = -1;
            if (can) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (m_ptr + i) % NREQ;
                    if (g < 0 && req_valid[k]) g = k;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("m_ready", 64'(req_ready), 64'(exp_ready));
            s = (g >= 0) ? g : m_ptr;
            chk("m_cmp_a",  64'(cmp_a),  64'(req_a[s*XLEN +: XLEN]));
            chk("m_cmp_b",  64'(cmp_b),  64'(req_b[s*XLEN +: XLEN]));
            chk("m_cmp_op", 64'(cmp_op), 64'(req_op[s*3 +: 3]));

            n_ptr = m_ptr; n_valid = m_valid; n_taken = m_taken;
            n_illegal = m_illegal; n_idx = m_idx; n_tag = m_tag;
            if (flush) begin
                n_valid = 0;
            end else if (g >= 0) begin
                n_valid   = 1;
                n_illegal = is_illegal(req_op[g*3 +: 3]);
                n_taken   = n_illegal ? 1'b0 :
                            cmp_fn(req_a[g*XLEN +: XLEN], req_b[g*XLEN +: XLEN], req_op[g*3 +: 3]);
                n_idx     = g;
                n_tag     = int'(req_tag[g*TAGW +: TAGW]);
                n_ptr     = (g + 1) % NREQ;
            end else if (rsp_ready) begin
                n_valid = 0;
            end
            n_live = 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && n_live) begin
            m_ptr = n_ptr; m_valid = n_valid; m_taken = n_taken;
            m_illegal = n_illegal; m_idx = n_idx; m_tag = n_tag;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [2:0] op, input logic [TAGW-1:0] tag);
        req_a[k*XLEN +: XLEN] = a;
        req_b[k*XLEN +: XLEN] = b;
        req_op[k*3 +: 3]      = op;
        req_tag[k*TAGW +: TAGW] = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;

        // Reset state with requests pending.
        neg();
        chk("rst_valid",   64'(rsp_valid),   64'(0));
        chk("rst_ready",   64'(req_ready),   64'(0));
        chk("rst_taken",   64'(rsp_taken),   64'(0));
        chk("rst_illegal", 64'(rsp_illegal), 64'(0));
        chk("rst_idx",     64'(rsp_idx),     64'(0));
        chk("rst_tag",     64'(rsp_tag),     64'(0));

        // Single request, BEQ 3==3.
        tick();
        rst_n = 1'b1;
        req_valid = 2'b01;
        set_req(0, 32'd3, 32'd3, BEQ, 4'd5);
        neg();
        chk("single_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        neg();
        chk("single_valid", 64'(rsp_valid), 64'(1));
        chk("single_taken", 64'(rsp_taken), 64'(1));
        chk("single_idx",   64'(rsp_idx),   64'(0));
        chk("single_tag",   64'(rsp_tag),   64'(5));

        // Reset mid-traffic with the slot full.
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        set_req(1, 32'd1, 32'd2, BLT, 4'd3);
        neg();
        chk("pre_rst_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        neg();
        chk("pre_rst_valid", 64'(rsp_valid), 64'(1));
        chk("pre_rst_idx",   64'(rsp_idx),   64'(1));
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'(0));
        chk("async_rst_ready", 64'(req_ready), 64'(0));
        chk("async_rst_idx",   64'(rsp_idx),   64'(0));
        tick();
        tick();

        // Round-robin, both requesters always valid; pointer restarts at 0.
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 32'hFFFF_FFFB, 32'd3, BLT,  4'd1);
        set_req(1, 32'hFFFF_FFFB, 32'd3, BLTU, 4'd2);
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("rr_ready", 64'(req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            if (i > 0) begin
                chk("rr_idx",   64'(rsp_idx),   64'((i - 1) % 2));
                chk("rr_taken", 64'(rsp_taken), ((i - 1) % 2 == 0) ? 64'(1) : 64'(0));
            end
            tick();
        end
        req_valid = 2'b00;
        neg();
        chk("rr_last_idx",   64'(rsp_idx),   64'(1));
        chk("rr_last_taken", 64'(rsp_taken), 64'(0));

        // Backpressure: slot full, consumer stalled for three cycles.
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, 32'd7, 32'd7, BGEU, 4'd9);
        neg();
        chk("bp_first_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b10;
        set_req(1, 32'd1, 32'd2, BNE, 4'd7);
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("bp_stall_ready", 64'(req_ready), 64'(0));
            chk("bp_stall_valid", 64'(rsp_valid), 64'(1));
            chk("bp_stall_tag",   64'(rsp_tag),   64'(9));
            chk("bp_stall_taken", 64'(rsp_taken), 64'(1));
            tick();
        end
        rsp_ready = 1'b1;
        neg();
        chk("bp_b2b_ready", 64'(req_ready), 64'(2'b10));
        chk("bp_b2b_idx",   64'(rsp_idx),   64'(0));
        tick();
        req_valid = 2'b00;
        neg();
        chk("bp_next_valid", 64'(rsp_valid), 64'(1));
        chk("bp_next_idx",   64'(rsp_idx),   64'(1));
        chk("bp_next_tag",   64'(rsp_tag),   64'(7));
        chk("bp_next_taken", 64'(rsp_taken), 64'(1));

        // Flush with a full slot and a pending requester.
        tick();
        req_valid = 2'b01;
        set_req(0, 32'd5, 32'd5, BGE, 4'd4);
        neg();
        chk("fl_load_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b10;
        set_req(1, 32'd1, 32'd1, BEQ, 4'd6);
        rsp_ready = 1'b0;
        flush = 1'b1;
        neg();
        chk("fl_ready", 64'(req_ready), 64'(0));
        chk("fl_valid", 64'(rsp_valid), 64'(1));
        chk("fl_taken", 64'(rsp_taken), 64'(1));
        tick();
        flush = 1'b0;
        rsp_ready = 1'b1;
        neg();
        chk("fl_after_valid", 64'(rsp_valid), 64'(0));
        chk("fl_after_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        neg();
        chk("fl_req1_idx", 64'(rsp_idx), 64'(1));
        chk("fl_req1_tag", 64'(rsp_tag), 64'(6));

        // Illegal cmpop on requester 1, equal operands.
        tick();
        req_valid = 2'b10;
        set_req(1, 32'd1, 32'd1, BBAD, 4'd11);
        neg();
        chk("ill_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        neg();
        chk("ill_valid",   64'(rsp_valid),   64'(1));
        chk("ill_illegal", 64'(rsp_illegal), 64'(1));
        chk("ill_taken",   64'(rsp_taken),   64'(0));
        chk("ill_idx",     64'(rsp_idx),     64'(1));
        chk("ill_tag",     64'(rsp_tag),     64'(11));
        tick();
        req_valid = 2'b11;
        set_req(0, 32'd2, 32'd2, BEQ, 4'd1);
        set_req(1, 32'd2, 32'd3, BNE, 4'd2);
        neg();
        chk("ill_ptr_wrap", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        neg();
        chk("ill_next_illegal", 64'(rsp_illegal), 64'(0));
        chk("ill_next_taken",   64'(rsp_taken),   64'(1));
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
